// File: rtl/l2_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : l2_port_arbiter_pkg
// Brief    : Shared types and line-geometry constants for the L2 port arbiter.
// Revision : 1.0  initial release
// ============================================================================
package l2_port_arbiter_pkg;

    localparam int unsigned C_ADDR_W = 12;
    localparam int unsigned C_DATA_W = 128;
    localparam int unsigned C_SEL_W  = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY0   = 2'd1,
        ST_BUSY1   = 2'd2,
        ST_RECOVER = 2'd3
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/l2_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : l2_port_arbiter_if
// Brief    : Single-beat Wishbone line-transfer bundle with master/slave views.
// Revision : 1.0  initial release
// ============================================================================
interface l2_port_arbiter_if
    import l2_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = C_ADDR_W,
    parameter int unsigned DATA_W = C_DATA_W,
    parameter int unsigned SEL_W  = C_SEL_W
);
    logic              cyc;
    logic              stb;
    logic              we;
    logic [ADDR_W-1:0] adr;
    logic [DATA_W-1:0] dat_m;
    logic [SEL_W-1:0]  sel;
    logic              ack;
    logic [DATA_W-1:0] dat_s;

    modport master (
        output cyc, stb, we, adr, dat_m, sel,
        input  ack, dat_s
    );

    modport slave (
        input  cyc, stb, we, adr, dat_m, sel,
        output ack, dat_s
    );
endinterface
`default_nettype wire

// File: rtl/l2_port_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : l2_port_arbiter_rr_pick
// Brief    : Combinational two-requester round-robin chooser.
// Revision : 1.0  initial release
// ============================================================================
module l2_port_arbiter_rr_pick (
    input  wire logic req0_i,
    input  wire logic req1_i,
    input  wire logic last_grant_i,
    output logic      valid_o,
    output logic      pick_o
);
    assign valid_o = req0_i | req1_i;
    // On a tie the requester that did not win last time takes the port.
    assign pick_o  = (req0_i & req1_i) ? ~last_grant_i : req1_i;
endmodule
`default_nettype wire

// File: rtl/l2_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : l2_port_arbiter
// Brief    : Two-master (I$/D$) to one-slave Wishbone line arbiter, RR ties.
// Revision : 1.0  initial release
// ============================================================================
module l2_port_arbiter
    import l2_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = C_ADDR_W,
    parameter int unsigned DATA_W = C_DATA_W,
    parameter int unsigned SEL_W  = C_SEL_W
)(
    input  wire logic         clk,
    input  wire logic         rst_n,
    l2_port_arbiter_if.slave  m0_if,
    l2_port_arbiter_if.slave  m1_if,
    l2_port_arbiter_if.master s_if
);
    arb_state_t        state_q, state_d;
    logic              last_grant_q, last_grant_d;

    logic              w_valid;
    logic              w_pick;

    logic              w_s_cyc, w_s_stb, w_s_we;
    logic [ADDR_W-1:0] w_s_adr;
    logic [DATA_W-1:0] w_s_dat_m;
    logic [SEL_W-1:0]  w_s_sel;
    logic              w_m0_ack, w_m1_ack;
    logic [DATA_W-1:0] w_m0_dat_s, w_m1_dat_s;

    l2_port_arbiter_rr_pick u_rr_pick (
        .req0_i       (m0_if.cyc & m0_if.stb),
        .req1_i       (m1_if.cyc & m1_if.stb),
        .last_grant_i (last_grant_q),
        .valid_o      (w_valid),
        .pick_o       (w_pick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        w_s_cyc      = 1'b0;
        w_s_stb      = 1'b0;
        w_s_we       = 1'b0;
        w_s_adr      = '0;
        w_s_dat_m    = '0;
        w_s_sel      = '0;
        w_m0_ack     = 1'b0;
        w_m1_ack     = 1'b0;
        w_m0_dat_s   = '0;
        w_m1_dat_s   = '0;

        case (state_q)
            ST_IDLE: begin
                if (w_valid) begin
                    state_d      = w_pick ? ST_BUSY1 : ST_BUSY0;
                    last_grant_d = w_pick;
                end
            end
            ST_BUSY0: begin
                w_s_cyc    = m0_if.cyc;
                w_s_stb    = m0_if.cyc & m0_if.stb;
                w_s_we     = m0_if.we;
                w_s_adr    = m0_if.adr;
                w_s_dat_m  = m0_if.dat_m;
                w_s_sel    = m0_if.sel;
                w_m0_ack   = s_if.ack;
                w_m0_dat_s = s_if.dat_s;
                if (s_if.ack) begin
                    state_d = ST_RECOVER;
                end else if (!m0_if.cyc) begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY1: begin
                w_s_cyc    = m1_if.cyc;
                w_s_stb    = m1_if.cyc & m1_if.stb;
                w_s_we     = m1_if.we;
                w_s_adr    = m1_if.adr;
                w_s_dat_m  = m1_if.dat_m;
                w_s_sel    = m1_if.sel;
                w_m1_ack   = s_if.ack;
                w_m1_dat_s = s_if.dat_s;
                if (s_if.ack) begin
                    state_d = ST_RECOVER;
                end else if (!m1_if.cyc) begin
                    state_d = ST_IDLE;
                end
            end
            // One quiet cycle hides the served master's stale STB.
            ST_RECOVER: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign s_if.cyc    = w_s_cyc;
    assign s_if.stb    = w_s_stb;
    assign s_if.we     = w_s_we;
    assign s_if.adr    = w_s_adr;
    assign s_if.dat_m  = w_s_dat_m;
    assign s_if.sel    = w_s_sel;
    assign m0_if.ack   = w_m0_ack;
    assign m0_if.dat_s = w_m0_dat_s;
    assign m1_if.ack   = w_m1_ack;
    assign m1_if.dat_s = w_m1_dat_s;
endmodule
`default_nettype wire

// File: tb/tb_l2_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_l2_port_arbiter
// Brief    : Self-checking bench: directed scenarios plus randomized traffic.
// Revision : 1.0  initial release
// ============================================================================
module tb_l2_port_arbiter;
    import l2_port_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    l2_port_arbiter_if m0_if ();
    l2_port_arbiter_if m1_if ();
    l2_port_arbiter_if s_if ();

    l2_port_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .m0_if (m0_if),
        .m1_if (m1_if),
        .s_if  (s_if)
    );

    int n_checks = 0;
    int n_fail   = 0;

    bit           pend  [2];
    logic [11:0]  p_adr [2];
    logic         p_we  [2];
    logic [127:0] p_dat [2];
    logic [15:0]  p_sel [2];
    int           last_g;
    int           grants[$];
    int           w;

    task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply();
        m0_if.cyc   = pend[0];
        m0_if.stb   = pend[0];
        m0_if.we    = p_we[0];
        m0_if.adr   = p_adr[0];
        m0_if.dat_m = p_dat[0];
        m0_if.sel   = p_sel[0];
        m1_if.cyc   = pend[1];
        m1_if.stb   = pend[1];
        m1_if.we    = p_we[1];
        m1_if.adr   = p_adr[1];
        m1_if.dat_m = p_dat[1];
        m1_if.sel   = p_sel[1];
    endtask

    // Fresh payload whose address differs from the other master's.
    task automatic new_payload(input int m);
        p_adr[m] = 12'($urandom());
        if (p_adr[m] == p_adr[1-m]) p_adr[m] = p_adr[m] ^ 12'h001;
        p_we[m]  = 1'($urandom());
        p_dat[m] = rnd128();
        p_sel[m] = 16'($urandom());
    endtask

    // Round-robin rule: a lone requester wins; on a tie the one not served last wins.
    function automatic int model_pick();
        if (pend[0] && pend[1]) return 1 - last_g;
        return pend[1] ? 1 : 0;
    endfunction

    task automatic check_idle(input string tag);
        check_eq({tag, "_req"}, {s_if.cyc, s_if.stb, s_if.we, s_if.adr, s_if.sel}, '0);
        check_eq({tag, "_dat_m"}, s_if.dat_m, '0);
        check_eq({tag, "_acks"}, {m0_if.ack, m1_if.ack}, '0);
        check_eq({tag, "_dat_s"}, m0_if.dat_s | m1_if.dat_s, '0);
    endtask

    // Entered at posedge+1 of an IDLE cycle with requests applied; leaves at
    // posedge+1 of the IDLE cycle that follows the RECOVER cycle.
    task automatic run_transfer(input int dly, input logic [127:0] rd, input bit keep, output int obs);
        int exp_w;
        obs = -1;
        #2;
        check_idle("pre_grant");
        if (!pend[0] && !pend[1]) begin
            n_checks++;
            n_fail++;
            $display("FAIL no_request: got none expected a pending request");
        end
        exp_w = model_pick();
        step();
        #2;
        check_eq("grant_cyc", s_if.cyc, 1'b1);
        check_eq("grant_stb", s_if.stb, 1'b1);
        check_eq("grant_adr", s_if.adr, p_adr[exp_w]);
        check_eq("grant_we", s_if.we, p_we[exp_w]);
        check_eq("grant_dat_m", s_if.dat_m, p_dat[exp_w]);
        check_eq("grant_sel", s_if.sel, p_sel[exp_w]);
        check_eq("busy_acks", {m0_if.ack, m1_if.ack}, '0);
        for (int i = 0; i < dly; i++) begin
            step();
            #2;
            check_eq("hold_stb", s_if.stb, 1'b1);
            check_eq("hold_adr", s_if.adr, p_adr[exp_w]);
        end
        s_if.ack   = 1'b1;
        s_if.dat_s = rd;
        #2;
        if (m1_if.ack === 1'b1) obs = 1;
        else if (m0_if.ack === 1'b1) obs = 0;
        check_eq("ack_win", (exp_w == 1) ? m1_if.ack : m0_if.ack, 1'b1);
        check_eq("ack_win_dat", (exp_w == 1) ? m1_if.dat_s : m0_if.dat_s, rd);
        check_eq("ack_other", (exp_w == 1) ? m0_if.ack : m1_if.ack, 1'b0);
        check_eq("ack_other_dat", (exp_w == 1) ? m0_if.dat_s : m1_if.dat_s, '0);
        step();
        #2;
        check_idle("recover");
        s_if.ack   = 1'b0;
        s_if.dat_s = rnd128();
        step();
        last_g = exp_w;
        grants.push_back(obs);
        pend[exp_w] = keep;
        if (keep) new_payload(exp_w);
        apply();
    endtask

    initial begin
        rst_n  = 1'b0;
        last_g = 1;
        for (int m = 0; m < 2; m++) begin
            pend[m] = 1'b0;
            new_payload(m);
        end
        apply();
        s_if.ack   = 1'b0;
        s_if.dat_s = rnd128();

        repeat (3) @(posedge clk);
        #3;
        check_idle("reset");
        step();
        rst_n = 1'b1;

        // Simultaneous requests straight out of reset: m0 first, then m1 write.
        p_we[0]  = 1'b0;
        p_we[1]  = 1'b1;
        p_sel[1] = 16'hFFFF;
        pend[0]  = 1'b1;
        pend[1]  = 1'b1;
        apply();
        run_transfer(1, rnd128(), 1'b0, w);
        check_eq("tie_first", w, 0);
        run_transfer(2, rnd128(), 1'b0, w);
        check_eq("tie_second", w, 1);
        new_payload(0);
        new_payload(1);
        pend[0] = 1'b1;
        pend[1] = 1'b1;
        apply();
        run_transfer(0, rnd128(), 1'b0, w);
        check_eq("tie_again", w, 0);
        run_transfer(1, rnd128(), 1'b0, w);

        // Single read from the I-cache.
        p_adr[0] = 12'h1A3;
        p_we[0]  = 1'b0;
        pend[0]  = 1'b1;
        apply();
        run_transfer(3, 128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF, 1'b0, w);
        check_eq("single_read_m0", w, 0);
        #2;
        check_idle("after_single");

        // Abort: m1 drops CYC mid-transfer while m0 waits.
        step();
        new_payload(1);
        pend[1] = 1'b1;
        apply();
        #2;
        check_idle("abort_pre");
        step();
        new_payload(0);
        pend[0] = 1'b1;
        apply();
        #2;
        check_eq("abort_granted_stb", s_if.stb, 1'b1);
        check_eq("abort_granted_adr", s_if.adr, p_adr[1]);
        step();
        pend[1] = 1'b0;
        apply();
        #2;
        check_eq("abort_cyc_drop", s_if.cyc, 1'b0);
        check_eq("abort_stb_drop", s_if.stb, 1'b0);
        check_eq("abort_no_ack", m1_if.ack, 1'b0);
        step();
        last_g = 1;
        run_transfer(0, rnd128(), 1'b0, w);
        check_eq("abort_next_m0", w, 0);

        // Reset asserted in the middle of an m0 transfer.
        new_payload(0);
        pend[0] = 1'b1;
        apply();
        #2;
        check_idle("rst_pre");
        step();
        #2;
        check_eq("rst_busy_stb", s_if.stb, 1'b1);
        rst_n = 1'b0;
        #1;
        check_eq("rst_cyc_drop", s_if.cyc, 1'b0);
        check_eq("rst_stb_drop", s_if.stb, 1'b0);
        pend[0] = 1'b0;
        apply();
        step();
        step();
        rst_n  = 1'b1;
        last_g = 1;
        s_if.ack   = 1'b1;
        s_if.dat_s = rnd128();
        #2;
        check_eq("late_ack_m0", m0_if.ack, 1'b0);
        check_eq("late_ack_m1", m1_if.ack, 1'b0);
        check_eq("late_ack_dat", m0_if.dat_s, '0);
        step();
        s_if.ack = 1'b0;

        // Continuous contention: grants must alternate starting with m0.
        grants.delete();
        new_payload(0);
        new_payload(1);
        pend[0] = 1'b1;
        pend[1] = 1'b1;
        apply();
        for (int i = 0; i < 8; i++) begin
            run_transfer(int'($urandom_range(0, 2)), rnd128(), 1'b1, w);
        end
        for (int i = 0; i < 8; i++) begin
            check_eq("fair_order", grants[i], i % 2);
        end
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        apply();

        // Randomized traffic mix.
        for (int t = 0; t < 30; t++) begin
            for (int m = 0; m < 2; m++) begin
                if (!pend[m] && ($urandom_range(0, 1) == 1)) begin
                    new_payload(m);
                    pend[m] = 1'b1;
                end
            end
            if (!pend[0] && !pend[1]) begin
                int m;
                m = int'($urandom_range(0, 1));
                new_payload(m);
                pend[m] = 1'b1;
            end
            apply();
            run_transfer(int'($urandom_range(0, 3)), rnd128(), 1'($urandom_range(0, 1)), w);
        end
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        apply();
        step();
        #2;
        check_idle("final");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
